laplacian_window_gen: RTL and testbench
=======================================

Name: laplacian_window_gen

Overview:
- Streaming 3x3 window generator sitting directly upstream of the Laplacian #2 kernel stage.
- Accepts a raster-order 8-bit pixel stream one pixel per cycle and buffers two prior image rows in line buffers.
- Presents registered 3x3 neighbourhoods p1..p9 with a valid/ready handshake, one window per fully-interior centre pixel.
- The combinational kernel consumes p1..p9 while win_valid is high.

Parameters:
- IMG_W, 64, image width in pixels (>=3).
- IMG_H, 64, image height in lines (>=3).
- DATA_W, 8, pixel width in bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- pix_in  input  DATA_W  incoming pixel, raster order.
- pix_valid  input  1  pix_in is valid this cycle.
- pix_sof  input  1  qualifies pix_in as pixel (0,0) of a new frame; meaningful only with pix_valid.
- pix_ready  output  1  block can accept a pixel this cycle.
- p1..p9  output  DATA_W each  window: p1 p2 p3 = top row (left to right), p4 p5 p6 = middle row, p7 p8 p9 = bottom row; p5 = centre.
- win_valid  output  1  p1..p9 hold a valid window.
- win_ready  input  1  downstream accepts the window this cycle.

Behaviour:
- Reset (rst=1 at clk edge): col=0, row=0, win_valid=0, p1..p9=0, the window shift registers are cleared, and pix_ready=0 while rst is high. Line-buffer RAM is not reset; its contents never reach a valid window before being overwritten.
- pix_ready = !rst && (!win_valid || win_ready), combinational.
- Accept event: acc = pix_valid && pix_ready. No state changes without acc, except win_valid clearing on a downstream handshake.
- Line buffers: lb0[IMG_W] holds row r-1 and lb1[IMG_W] holds row r-2. On acc, read both at index col, then write lb1[col] <= lb0[col] and lb0[col] <= pix_in.
- Window shift on acc:
  - Columns shift left: p1<=p2, p2<=p3, p4<=p5, p5<=p6, p7<=p8, p8<=p9.
  - New right column: p3<=lb1[col], p6<=lb0[col], p9<=pix_in.
- Position counters on acc:
  - If pix_sof=1, the pixel is treated as (0,0). Counters then advance to col=1, row=0, discarding any partial frame.
  - Otherwise col increments. At col=IMG_W-1, col wraps to 0 and row increments.
  - At (IMG_H-1, IMG_W-1), both wrap to 0 (implicit next frame).
- Output valid:
  - On acc with the accepted pixel at row>=2 and col>=2, win_valid<=1 at the same edge. Latency is one clock from pixel acceptance to window presentation.
  - Centre pixel of that window is (row-1, col-1).
- win_valid clears when win_valid && win_ready && no qualifying acc at the same edge.
- Simultaneous downstream handshake and new qualifying accept: win_valid stays 1 with the new window. Full throughput is one window per cycle.
- Backpressure: while win_valid && !win_ready, pix_ready=0 and p1..p9, counters and line buffers hold.
- Row-start columns (col 0,1): windows straddle rows and are suppressed by the col>=2 rule; no border padding is produced.
- Windows per frame = (IMG_W-2)*(IMG_H-2).
- Counter widths are clog2(IMG_W) and clog2(IMG_H). There is no overflow beyond the explicit wraps.
- pix_sof mid-frame: the current partial frame is abandoned. The first valid window of the new frame appears only after two full rows plus three pixels.

Test Plan:
- Basic frame (IMG_W=4, IMG_H=4): stream pixel value = 4*row+col with win_ready=1 and pix_sof on the first pixel.
  - First win_valid appears one cycle after pixel 10 is accepted, with p1..p9 = 0,1,2,4,5,6,8,9,10.
  - The next windows are (1,2,3,5,6,7,9,10,11), then (4,5,6,8,9,10,12,13,14), then (5..7,9..11,13..15).
  - Exactly 4 valid windows in total.
- Backpressure: same frame, win_ready=0 for 5 cycles at the first window.
  - p1..p9 hold 0,1,2,4,5,6,8,9,10 and pix_ready=0 throughout.
  - On release, the remaining 3 windows follow with no loss or duplication.
- Bubbles: pix_valid toggling 1/0 every cycle.
  - Identical window sequence to the basic frame.
  - win_valid is never asserted twice for one pixel.
- Frame wrap: two back-to-back frames without pix_sof on the second, second frame values offset by 100.
  - The second frame's first window is 100,101,102,104,105,106,108,109,110.
  - 8 windows in total.
- Mid-frame resync: after 6 pixels, assert pix_sof with new frame data.
  - No window contains pre-resync pixels in the wrong position.
  - Window count restarts at 4.
- Reset mid-operation: assert rst for 1 cycle while win_valid=1.
  - Next cycle: win_valid=0, p1..p9=0, pix_ready=0 during rst, 1 after.
  - A fresh frame produces the basic-frame results.

Source files
------------

// File: rtl/laplacian_window_gen.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 shift window,
// emitting one registered neighbourhood per fully-interior centre pixel.
module laplacian_window_gen #(
  parameter int unsigned IMG_W  = 64,
  parameter int unsigned IMG_H  = 64,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              pix_valid,
  input  logic              pix_sof,
  output logic              pix_ready,
  output logic [DATA_W-1:0] p1,
  output logic [DATA_W-1:0] p2,
  output logic [DATA_W-1:0] p3,
  output logic [DATA_W-1:0] p4,
  output logic [DATA_W-1:0] p5,
  output logic [DATA_W-1:0] p6,
  output logic [DATA_W-1:0] p7,
  output logic [DATA_W-1:0] p8,
  output logic [DATA_W-1:0] p9,
  output logic              win_valid,
  input  logic              win_ready
);

  localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [CW-1:0]     col, cur_col, nxt_col;
  logic [RW-1:0]     row, cur_row, nxt_row;
  logic              acc, qual;
  logic [DATA_W-1:0] lb0 [IMG_W];
  logic [DATA_W-1:0] lb1 [IMG_W];
  logic [DATA_W-1:0] lb0_rd, lb1_rd;

  assign pix_ready = !rst && (!win_valid || win_ready);
  assign acc       = pix_valid && pix_ready;

  // Effective position of the incoming pixel (sof forces origin) and its successor
  always_comb begin
    cur_col = col;
    cur_row = row;
    nxt_col = '0;
    nxt_row = '0;
    if (pix_sof) begin
      cur_col = '0;
      cur_row = '0;
    end
    if (cur_col == CW'(IMG_W - 1)) begin
      nxt_col = '0;
      nxt_row = (cur_row == RW'(IMG_H - 1)) ? '0 : cur_row + RW'(1);
    end else begin
      nxt_col = cur_col + CW'(1);
      nxt_row = cur_row;
    end
  end

  assign qual   = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
  assign lb0_rd = lb0[cur_col];
  assign lb1_rd = lb1[cur_col];

  // Line buffers are plain RAM: no reset, writes only on accept
  always_ff @(posedge clk) begin
    if (acc) begin
      lb1[cur_col] <= lb0_rd;
      lb0[cur_col] <= pix_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      win_valid <= 1'b0;
      p1 <= '0; p2 <= '0; p3 <= '0;
      p4 <= '0; p5 <= '0; p6 <= '0;
      p7 <= '0; p8 <= '0; p9 <= '0;
    end else if (acc) begin
      p1 <= p2; p2 <= p3; p3 <= lb1_rd;
      p4 <= p5; p5 <= p6; p6 <= lb0_rd;
      p7 <= p8; p8 <= p9; p9 <= pix_in;
      col       <= nxt_col;
      row       <= nxt_row;
      win_valid <= qual;
    end else if (win_ready) begin
      win_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_laplacian_window_gen.sv
// Bench for laplacian_window_gen: image-array reference model with a per-cycle
// compare process, directed frames plus randomized data and handshakes.
module tb_laplacian_window_gen;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 4;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] pix_in = '0;
  logic          pix_valid = 1'b0;
  logic          pix_sof = 1'b0;
  logic          pix_ready;
  logic [DW-1:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
  logic          win_valid;
  logic          win_ready = 1'b1;

  laplacian_window_gen #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_sof(pix_sof), .pix_ready(pix_ready),
    .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5), .p6(p6), .p7(p7), .p8(p8), .p9(p9),
    .win_valid(win_valid), .win_ready(win_ready)
  );

  always #5 clk = ~clk;

  wire [71:0] win = {p1, p2, p3, p4, p5, p6, p7, p8, p9};

  int          n_pass = 0;
  int          n_tot  = 0;
  logic [71:0] q[$];
  logic [71:0] wlog[$];
  logic [7:0]  img [H][W];
  int          mrow = 0;
  int          mcol = 0;
  bit          mon_en = 1'b0;
  bit          done;
  logic        exp_ready;
  logic [71:0] ew;
  int          r, c;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Window whose top-left pixel value is t in a 4-wide ramp image
  function automatic logic [71:0] ramp_win(input int t);
    logic [71:0] w;
    w = '0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        w = {w[63:0], 8'(t + 4 * dr + dc)};
    return w;
  endfunction

  // Reference model: place each accepted pixel into an image, emit interior windows
  always @(negedge clk) begin
    if (mon_en) begin
      exp_ready = !rst && (q.size() == 0 || win_ready);
      chk("pix_ready", pix_ready, exp_ready);
      chk("win_valid", win_valid, q.size() != 0);
      if (q.size() != 0) chk("window", win, q[0]);
      if (rst) begin
        q.delete();
        mrow = 0;
        mcol = 0;
      end else begin
        if (q.size() != 0 && win_ready) wlog.push_back(q.pop_front());
        if (pix_valid && exp_ready) begin
          if (pix_sof) begin mrow = 0; mcol = 0; end
          r = mrow;
          c = mcol;
          img[r][c] = pix_in;
          if (r >= 2 && c >= 2) begin
            ew = '0;
            for (int dr = 0; dr < 3; dr++)
              for (int dc = 0; dc < 3; dc++)
                ew = {ew[63:0], img[r-2+dr][c-2+dc]};
            q.push_back(ew);
          end
          mcol = c + 1;
          mrow = r;
          if (mcol == W) begin
            mcol = 0;
            mrow = (r + 1 == H) ? 0 : r + 1;
          end
        end
      end
    end
  end

  task automatic send_pix(input logic [7:0] v, input logic sof);
    int n;
    @(posedge clk); #1;
    pix_in = v; pix_valid = 1'b1; pix_sof = sof;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pix_ready && n < 200);
    if (!pix_ready) chk("pix_accept_timeout", pix_ready, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      pix_valid = 1'b0; pix_sof = 1'b0;
    end
  endtask

  task automatic send_frame(input int base, input bit sof_first, input bit bubble, input int npix);
    for (int i = 0; i < npix; i++) begin
      send_pix(8'(base + i), sof_first && (i == 0));
      if (bubble) idle(1);
    end
  endtask

  task automatic send_rnd_frame(input bit sof_first);
    for (int i = 0; i < W * H; i++) begin
      send_pix(8'($urandom), sof_first && (i == 0));
      if ($urandom_range(0, 2) == 0) idle(1 + $urandom_range(0, 1));
    end
  endtask

  task automatic chk_basic(input string name);
    chk({name, "_count"}, wlog.size(), 4);
    chk({name, "_w0"}, wlog[0], {8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10});
    chk({name, "_w1"}, wlog[1], ramp_win(1));
    chk({name, "_w2"}, wlog[2], ramp_win(4));
    chk({name, "_w3"}, wlog[3], ramp_win(5));
  endtask

  initial begin
    int n;
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_win_valid", win_valid, 1'b0);
    chk("rst_window", win, '0);
    chk("rst_pix_ready", pix_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic frame
    wlog.delete();
    send_frame(0, 1, 0, 16);
    idle(8);
    chk_basic("basic");

    // Backpressure at the first window
    wlog.delete();
    win_ready = 1'b0;
    fork
      send_frame(0, 1, 0, 16);
      begin
        n = 0;
        while (!win_valid && n < 300) begin @(negedge clk); n++; end
        chk("bp_seen", win_valid, 1'b1);
        for (int k = 0; k < 5; k++) begin
          chk("bp_hold_win", win, {8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10});
          chk("bp_hold_ready", pix_ready, 1'b0);
          @(negedge clk);
        end
        @(posedge clk); #1;
        win_ready = 1'b1;
      end
    join
    idle(8);
    chk_basic("bp");

    // Bubbles on pix_valid
    wlog.delete();
    send_frame(0, 1, 1, 16);
    idle(8);
    chk_basic("bubble");

    // Two frames, second without sof
    wlog.delete();
    send_frame(0, 1, 0, 16);
    send_frame(100, 0, 0, 16);
    idle(8);
    chk("wrap_count", wlog.size(), 8);
    chk("wrap_w4", wlog[4], {8'd100, 8'd101, 8'd102, 8'd104, 8'd105, 8'd106, 8'd108, 8'd109, 8'd110});
    chk("wrap_w7", wlog[7], ramp_win(105));

    // Mid-frame resync after 6 pixels
    wlog.delete();
    send_frame(200, 1, 0, 6);
    send_frame(0, 1, 0, 16);
    idle(8);
    chk_basic("resync");

    // Reset while a window is held
    wlog.delete();
    win_ready = 1'b0;
    send_frame(0, 1, 0, 11);
    idle(2);
    chk("prerst_valid", win_valid, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("inrst_ready", pix_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    win_ready = 1'b1;
    @(negedge clk);
    chk("postrst_valid", win_valid, 1'b0);
    chk("postrst_window", win, '0);
    chk("postrst_ready", pix_ready, 1'b1);
    wlog.delete();
    send_frame(0, 1, 0, 16);
    idle(8);
    chk_basic("after_rst");

    // Randomized data, bubbles and backpressure
    wlog.delete();
    done = 1'b0;
    fork
      begin
        for (int f = 0; f < 3; f++) send_rnd_frame(f == 0);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          win_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    win_ready = 1'b1;
    idle(12);
    chk("rnd_count", wlog.size(), 12);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
